// File: rtl/br_redirect_ctrl.sv
// Branch redirect controller. Sits after the branch FU in EXE and turns each
// resolved control transfer into one of three outcomes:
//   - the prediction was correct: nothing happens;
//   - the prediction was wrong: IF/ID is flushed, then a redirect is sent to fetch;
//   - the target is misaligned: an exception request is sent to the trap logic.
// It also keeps saturating counts of branches and mispredicts.
// Every output is a register, so no input reaches an output combinationally.
module br_redirect_ctrl #(
  parameter int PC_SZ     = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_SZ    = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              exe_valid_in,
  output logic              exe_rdy_out,
  input  logic              is_br_in,
  input  logic [PC_SZ-1:0]  pc_in,
  input  logic [PC_SZ-1:0]  br_pc_in,
  input  logic [PC_SZ-1:0]  pred_pc_in,
  input  logic              mis_in,
  input  logic              kill_in,
  output logic              flush_out,
  output logic              redir_valid_out,
  output logic [PC_SZ-1:0]  redir_pc_out,
  input  logic              redir_ack_in,
  output logic              exc_valid_out,
  output logic [PC_SZ-1:0]  exc_pc_out,
  output logic [PC_SZ-1:0]  exc_tval_out,
  input  logic              exc_ack_in,
  output logic [CNT_SZ-1:0] br_cnt_out,
  output logic [CNT_SZ-1:0] mispred_cnt_out
);

  // Flush length. A value of 0 is raised to 1 and the value is limited to the
  // 4-bit counter range.
  localparam logic [3:0] FLUSH_LD = (FLUSH_CYC < 1)  ? 4'd1  :
                                    (FLUSH_CYC > 15) ? 4'd15 : 4'(FLUSH_CYC);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIR, EXC} state_t;

  state_t     state;
  logic [3:0] flush_cnt;
  logic       take_br;

  // A branch-class instruction is taken only when ready is already high and no
  // kill is present. Because ready is a register, accept never has a path to an output.
  assign take_br = (state == IDLE) & exe_valid_in & exe_rdy_out & is_br_in & ~kill_in;

  // Sequencer. The next state and all registered outputs are produced together.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state           <= IDLE;
      exe_rdy_out     <= 1'b1;
      flush_out       <= 1'b0;
      redir_valid_out <= 1'b0;
      exc_valid_out   <= 1'b0;
      redir_pc_out    <= '0;
      exc_pc_out      <= '0;
      exc_tval_out    <= '0;
      flush_cnt       <= '0;
      br_cnt_out      <= '0;
      mispred_cnt_out <= '0;
    end else if (kill_in) begin
      // Kill always wins. The controller drops to IDLE, and ready stays low for
      // one cycle because the kill is seen through this register.
      state           <= IDLE;
      exe_rdy_out     <= 1'b0;
      flush_out       <= 1'b0;
      redir_valid_out <= 1'b0;
      exc_valid_out   <= 1'b0;
      flush_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          exe_rdy_out <= 1'b1;
          if (take_br) begin
            if (br_cnt_out != '1) br_cnt_out <= br_cnt_out + 1'b1;
            if (mis_in) begin
              state         <= EXC;
              exe_rdy_out   <= 1'b0;
              exc_valid_out <= 1'b1;
              flush_out     <= 1'b1;
              exc_pc_out    <= pc_in;
              exc_tval_out  <= br_pc_in;
            end else if (br_pc_in != pred_pc_in) begin
              state        <= FLUSH;
              exe_rdy_out  <= 1'b0;
              flush_out    <= 1'b1;
              redir_pc_out <= br_pc_in;
              flush_cnt    <= FLUSH_LD;
              if (mispred_cnt_out != '1) mispred_cnt_out <= mispred_cnt_out + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt <= 4'd1) begin
            state           <= REDIR;
            flush_out       <= 1'b0;
            redir_valid_out <= 1'b1;
            flush_cnt       <= '0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        REDIR: begin
          if (redir_ack_in) begin
            state           <= IDLE;
            redir_valid_out <= 1'b0;
            exe_rdy_out     <= 1'b1;
          end
        end
        EXC: begin
          if (exc_ack_in) begin
            state         <= IDLE;
            exc_valid_out <= 1'b0;
            flush_out     <= 1'b0;
            exe_rdy_out   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed bench for br_redirect_ctrl (PC_SZ=32, FLUSH_CYC=2, CNT_SZ=4).
module tb_br_redirect_ctrl;
  localparam int PC_SZ = 32;
  localparam int CNT_SZ = 4;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              exe_valid_in, exe_rdy_out, is_br_in;
  logic [PC_SZ-1:0]  pc_in, br_pc_in, pred_pc_in;
  logic              mis_in, kill_in;
  logic              flush_out, redir_valid_out, redir_ack_in;
  logic [PC_SZ-1:0]  redir_pc_out, exc_pc_out, exc_tval_out;
  logic              exc_valid_out, exc_ack_in;
  logic [CNT_SZ-1:0] br_cnt_out, mispred_cnt_out;

  int n_cmp = 0;
  int n_bad = 0;

  br_redirect_ctrl #(.PC_SZ(PC_SZ), .FLUSH_CYC(2), .CNT_SZ(CNT_SZ)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .exe_valid_in(exe_valid_in), .exe_rdy_out(exe_rdy_out), .is_br_in(is_br_in),
    .pc_in(pc_in), .br_pc_in(br_pc_in), .pred_pc_in(pred_pc_in),
    .mis_in(mis_in), .kill_in(kill_in),
    .flush_out(flush_out), .redir_valid_out(redir_valid_out), .redir_pc_out(redir_pc_out),
    .redir_ack_in(redir_ack_in),
    .exc_valid_out(exc_valid_out), .exc_pc_out(exc_pc_out), .exc_tval_out(exc_tval_out),
    .exc_ack_in(exc_ack_in),
    .br_cnt_out(br_cnt_out), .mispred_cnt_out(mispred_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge, where outputs are read and
  // inputs are changed.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] br, input logic [31:0] pred,
                          input logic mis);
    exe_valid_in = 1'b1; is_br_in = 1'b1;
    pc_in = pc; br_pc_in = br; pred_pc_in = pred; mis_in = mis;
  endtask

  task automatic idle_in();
    exe_valid_in = 1'b0; is_br_in = 1'b0; mis_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b0; kill_in = 1'b0; redir_ack_in = 1'b0; exc_ack_in = 1'b0;
    pc_in = '0; br_pc_in = '0; pred_pc_in = '0;
    idle_in();
    step(); step();
    chk("rst_flush", flush_out, 0);
    chk("rst_redir", redir_valid_out, 0);
    chk("rst_exc", exc_valid_out, 0);
    chk("rst_brcnt", br_cnt_out, 0);
    chk("rst_mpcnt", mispred_cnt_out, 0);
    reset_in = 1'b1;
    step();
    chk("rst_rdy", exe_rdy_out, 1);

    // Correct prediction (bne)
    drive_br(32'h100, 32'h104, 32'h104, 1'b0);
    step(); idle_in();
    chk("ok_flush", flush_out, 0);
    chk("ok_rdy", exe_rdy_out, 1);
    chk("ok_brcnt", br_cnt_out, 1);
    chk("ok_mpcnt", mispred_cnt_out, 0);

    // Mispredict: accept at edge t
    drive_br(32'h1f0, 32'h200, 32'h104, 1'b0);
    step(); idle_in();                        // cycle t+1
    chk("mp_flush1", flush_out, 1);
    chk("mp_rdy1", exe_rdy_out, 0);
    chk("mp_mpcnt", mispred_cnt_out, 1);
    step();                                   // cycle t+2
    chk("mp_flush2", flush_out, 1);
    chk("mp_redir2", redir_valid_out, 0);
    step();                                   // cycle t+3
    chk("mp_flush3", flush_out, 0);
    chk("mp_redir3", redir_valid_out, 1);
    chk("mp_redirpc", redir_pc_out, 32'h200);
    step(); step();
    chk("mp_hold_v", redir_valid_out, 1);
    chk("mp_hold_pc", redir_pc_out, 32'h200);
    redir_ack_in = 1'b1;
    step(); redir_ack_in = 1'b0;
    chk("mp_ack_v", redir_valid_out, 0);
    chk("mp_ack_rdy", exe_rdy_out, 1);
    chk("mp_brcnt", br_cnt_out, 2);

    // Misaligned jalr, which also mispredicts: it must go to EXC and not to FLUSH
    drive_br(32'h80, 32'h102, 32'h84, 1'b1);
    step(); idle_in();
    chk("mis_exc", exc_valid_out, 1);
    chk("mis_flush", flush_out, 1);
    chk("mis_redir", redir_valid_out, 0);
    chk("mis_pc", exc_pc_out, 32'h80);
    chk("mis_tval", exc_tval_out, 32'h102);
    chk("mis_mpcnt", mispred_cnt_out, 1);
    chk("mis_brcnt", br_cnt_out, 3);
    step();
    chk("mis_hold", exc_valid_out, 1);
    step();
    chk("mis_no_redir", redir_valid_out, 0);
    exc_ack_in = 1'b1;
    step(); exc_ack_in = 1'b0;
    chk("mis_ack_v", exc_valid_out, 0);
    chk("mis_ack_fl", flush_out, 0);
    chk("mis_ack_rdy", exe_rdy_out, 1);

    // Acks that arrive while IDLE have no effect
    redir_ack_in = 1'b1; exc_ack_in = 1'b1;
    step(); redir_ack_in = 1'b0; exc_ack_in = 1'b0;
    chk("sp_redir", redir_valid_out, 0);
    chk("sp_rdy", exe_rdy_out, 1);

    // Kill during FLUSH, arriving together with a new mispredicting instruction
    drive_br(32'h2f0, 32'h300, 32'h104, 1'b0);
    step();
    chk("k_flush", flush_out, 1);
    kill_in = 1'b1;
    drive_br(32'h2f4, 32'h400, 32'h104, 1'b0);
    step(); kill_in = 1'b0; idle_in();
    chk("k_flush0", flush_out, 0);
    chk("k_redir0", redir_valid_out, 0);
    chk("k_brcnt", br_cnt_out, 4);
    chk("k_mpcnt", mispred_cnt_out, 2);
    step(); step(); step();
    chk("k_noredir", redir_valid_out, 0);
    chk("k_rdy", exe_rdy_out, 1);
    chk("k_brcnt2", br_cnt_out, 4);

    // Saturation: 17 correctly predicted back-to-back branches, starting from 4
    drive_br(32'h500, 32'h504, 32'h504, 1'b0);
    for (int i = 0; i < 17; i++) step();
    idle_in();
    chk("sat_brcnt", br_cnt_out, 15);
    chk("sat_mpcnt", mispred_cnt_out, 2);
    chk("sat_rdy", exe_rdy_out, 1);

    // Reset asserted in the middle of REDIR
    drive_br(32'h600, 32'h700, 32'h604, 1'b0);
    step(); idle_in();
    step(); step();
    chk("r_redir_pre", redir_valid_out, 1);
    #2 reset_in = 1'b0;
    #1;
    chk("r_redir", redir_valid_out, 0);
    chk("r_flush", flush_out, 0);
    chk("r_exc", exc_valid_out, 0);
    chk("r_redirpc", redir_pc_out, 0);
    chk("r_brcnt", br_cnt_out, 0);
    chk("r_mpcnt", mispred_cnt_out, 0);
    step();
    reset_in = 1'b1;
    step();
    chk("r_rdy", exe_rdy_out, 1);
    chk("r_redir_post", redir_valid_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
